// File: rtl/ctrl_pipeline_unit_if.sv
// Decode/pipeline control bus: instruction-side inputs plus every decoded control output.
interface ctrl_pipeline_unit_if #(
  parameter int OPW    = 5,
  parameter int ALUW   = 4,
  parameter int STAGES = 3
);
  logic [OPW-1:0]    opcode;
  logic              stall;
  logic              jump_occured;
  logic [ALUW-1:0]   alu_operation;
  logic [ALUW-1:0]   alu_operation_ex;
  logic              mem_read;
  logic              mem_write;
  logic              wb;
  logic              push_signal;
  logic              pop_signal;
  logic              in_port_signal;
  logic              out_port_signal;
  logic              one_operand;
  logic              direct_jump;
  logic [1:0]        jump_type_signal;
  logic              call_signal;
  logic              ret_signal;
  logic              reti_signal;
  logic [STAGES-1:0] mem_read_pipe;
  logic [STAGES-1:0] mem_write_pipe;
  logic [STAGES-1:0] wb_pipe;

  modport master (
    output opcode, stall, jump_occured,
    input  alu_operation, alu_operation_ex, mem_read, mem_write, wb,
           push_signal, pop_signal, in_port_signal, out_port_signal,
           one_operand, direct_jump, jump_type_signal,
           call_signal, ret_signal, reti_signal,
           mem_read_pipe, mem_write_pipe, wb_pipe
  );

  modport slave (
    input  opcode, stall, jump_occured,
    output alu_operation, alu_operation_ex, mem_read, mem_write, wb,
           push_signal, pop_signal, in_port_signal, out_port_signal,
           one_operand, direct_jump, jump_type_signal,
           call_signal, ret_signal, reti_signal,
           mem_read_pipe, mem_write_pipe, wb_pipe
  );
endinterface

// File: rtl/ctrl_pipeline_unit.sv
// Instruction decoder with bubble FSM and delayed control pipes.
// Define CTRL_CALL_RET_EN to decode CALL/RET/RETI (opcodes 20/21/22).
module ctrl_pipeline_unit #(
  parameter int OPW    = 5,
  parameter int ALUW   = 4,
  parameter int STAGES = 3
) (
  input logic                 clk,
  input logic                 rst,
  ctrl_pipeline_unit_if.slave bus
);

  localparam logic [1:0] DECODE     = 2'd0;
  localparam logic [1:0] IMM_BUBBLE = 2'd1;
  localparam logic [1:0] JMP_BUBBLE = 2'd2;

  typedef struct packed {
    logic [ALUW-1:0] alu;
    logic            mem_read;
    logic            mem_write;
    logic            wb;
    logic            push;
    logic            pop;
    logic            in_port;
    logic            out_port;
    logic            one_operand;
    logic            direct_jump;
    logic [1:0]      jump_type;
  } ctrl_t;

  logic [1:0]        state_q, state_d;
  ctrl_t             dec_q, dec_d;
  logic [4:0]        op5;
  logic              op_valid;
  logic              advance;
  logic [STAGES-1:0] mr_pipe_q, mw_pipe_q, wb_pipe_q;
  logic [ALUW-1:0]   alu_ex_q;

`ifdef CTRL_CALL_RET_EN
  logic call_d, ret_d, reti_d;
  logic call_q, ret_q, reti_q;
`endif

  // Wider opcodes are only legal when everything above bit 4 is zero.
  assign op_valid = (bus.opcode >> 5) == '0;
  assign op5      = 5'(bus.opcode);
  assign advance  = bus.jump_occured || !bus.stall;

  always_comb begin
    dec_d   = '0;
    state_d = DECODE;
`ifdef CTRL_CALL_RET_EN
    call_d  = 1'b0;
    ret_d   = 1'b0;
    reti_d  = 1'b0;
`endif
    if (state_q == DECODE && op_valid) begin
      case (op5)
        5'd1:  dec_d.alu = ALUW'(11);
        5'd2:  dec_d.alu = ALUW'(12);
        5'd3:  dec_d.alu = ALUW'(1);
        5'd4:  dec_d.alu = ALUW'(2);
        5'd5:  dec_d.alu = ALUW'(3);
        5'd6:  dec_d.in_port = 1'b1;
        5'd7:  dec_d.out_port = 1'b1;
        5'd8:  dec_d.push = 1'b1;
        5'd9:  dec_d.pop = 1'b1;
        5'd10: begin dec_d.alu = ALUW'(13); dec_d.mem_read = 1'b1; end
        5'd12: begin dec_d.alu = ALUW'(13); dec_d.mem_write = 1'b1; end
        5'd14: begin dec_d.alu = ALUW'(14); state_d = IMM_BUBBLE; end
        5'd16: dec_d.jump_type = 2'd1;
        5'd17: dec_d.jump_type = 2'd2;
        5'd18: dec_d.jump_type = 2'd3;
        5'd19: begin dec_d.direct_jump = 1'b1; state_d = JMP_BUBBLE; end
`ifdef CTRL_CALL_RET_EN
        5'd20: begin call_d = 1'b1; dec_d.push = 1'b1; state_d = JMP_BUBBLE; end
        5'd21: begin ret_d  = 1'b1; dec_d.pop  = 1'b1; state_d = JMP_BUBBLE; end
        5'd22: begin reti_d = 1'b1; dec_d.pop  = 1'b1; state_d = JMP_BUBBLE; end
`endif
        5'd24: dec_d.alu = ALUW'(4);
        5'd25: dec_d.alu = ALUW'(5);
        5'd26: dec_d.alu = ALUW'(6);
        5'd28: dec_d.alu = ALUW'(7);
        5'd29: dec_d.alu = ALUW'(8);
        5'd30: begin dec_d.alu = ALUW'(9);  state_d = IMM_BUBBLE; end
        5'd31: begin dec_d.alu = ALUW'(10); state_d = IMM_BUBBLE; end
        default: ;
      endcase
      dec_d.one_operand = (op5 == 5'd3) || (op5 == 5'd4) || (op5 == 5'd5);
      // Flag ops (SETC/CLRC) use the ALU but never write a register.
      dec_d.wb = (dec_d.alu != '0 || dec_d.mem_read) && !dec_d.mem_write &&
                 dec_d.alu != ALUW'(11) && dec_d.alu != ALUW'(12);
    end
  end

  // A taken jump overrides stall; it also kills writes of the entry entering stage 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DECODE;
      dec_q     <= '0;
      mr_pipe_q <= '0;
      mw_pipe_q <= '0;
      wb_pipe_q <= '0;
      alu_ex_q  <= '0;
    end else if (advance) begin
      state_q   <= bus.jump_occured ? DECODE : state_d;
      dec_q     <= bus.jump_occured ? ctrl_t'('0) : dec_d;
      mr_pipe_q <= STAGES'({mr_pipe_q, dec_q.mem_read});
      mw_pipe_q <= STAGES'({mw_pipe_q, dec_q.mem_write && !bus.jump_occured});
      wb_pipe_q <= STAGES'({wb_pipe_q, dec_q.wb && !bus.jump_occured});
      alu_ex_q  <= dec_q.alu;
    end
  end

`ifdef CTRL_CALL_RET_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      call_q <= 1'b0;
      ret_q  <= 1'b0;
      reti_q <= 1'b0;
    end else if (advance) begin
      call_q <= call_d && !bus.jump_occured;
      ret_q  <= ret_d  && !bus.jump_occured;
      reti_q <= reti_d && !bus.jump_occured;
    end
  end

  assign bus.call_signal = call_q;
  assign bus.ret_signal  = ret_q;
  assign bus.reti_signal = reti_q;
`else
  assign bus.call_signal = 1'b0;
  assign bus.ret_signal  = 1'b0;
  assign bus.reti_signal = 1'b0;
`endif

  assign bus.alu_operation    = dec_q.alu;
  assign bus.mem_read         = dec_q.mem_read;
  assign bus.mem_write        = dec_q.mem_write;
  assign bus.wb               = dec_q.wb;
  assign bus.push_signal      = dec_q.push;
  assign bus.pop_signal       = dec_q.pop;
  assign bus.in_port_signal   = dec_q.in_port;
  assign bus.out_port_signal  = dec_q.out_port;
  assign bus.one_operand      = dec_q.one_operand;
  assign bus.direct_jump      = dec_q.direct_jump;
  assign bus.jump_type_signal = dec_q.jump_type;
  assign bus.mem_read_pipe    = mr_pipe_q;
  assign bus.mem_write_pipe   = mw_pipe_q;
  assign bus.wb_pipe          = wb_pipe_q;
  assign bus.alu_operation_ex = alu_ex_q;

endmodule
